// File: rtl/fifo_sync_pkg.sv
// Shared definitions for the synchronous FIFO: default geometry and the
// per-cycle operation classification used by the occupancy counter.
package fifo_sync_pkg;

    // Default word width and address width (depth = 2**DEFAULT_M words)
    localparam int DEFAULT_NB = 16;
    localparam int DEFAULT_M  = 9;

    // What happens to the FIFO on a given clock edge
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Combine the qualified write and read strobes into one operation code
    function automatic fifo_op_e classify_op(input logic wr, input logic rd);
        return fifo_op_e'({wr, rd});
    endfunction

endpackage

// File: rtl/FIFOInterface.sv
// Valid/ready handshake bundle shared by every FIFO-connected block.
// The producer drives data/valid, the consumer drives ready.
interface FIFOInterface #(
    parameter int num_bits = 8
) (
    input logic clk
);

    logic [num_bits-1:0] data;
    logic                valid;
    logic                ready;

    // Consumer-side view: the block receives data and answers with ready
    modport in (
        input  data,
        input  valid,
        output ready,
        input  clk
    );

    // Producer-side view: the block presents data and samples ready
    modport out (
        output data,
        output valid,
        input  ready,
        input  clk
    );

endinterface

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO. The oldest word is always
// presented on out.data while out.valid is high; a handshake on either side
// moves the corresponding pointer. Occupancy is kept in a registered counter
// that also drives the full/empty flags.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int Nb = DEFAULT_NB,
    parameter int M  = DEFAULT_M
) (
    input  logic         clk,
    input  logic         reset,
    FIFOInterface.in     in,
    FIFOInterface.out    out,
    output logic [M:0]   count
);

    localparam int D = 1 << M;

    localparam logic [M-1:0] PTR_ONE    = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M:0]   COUNT_ONE  = {{M{1'b0}}, 1'b1};
    localparam logic [M:0]   COUNT_FULL = {1'b1, {M{1'b0}}};

    logic [Nb-1:0] mem [D];

    logic [M-1:0] wr_ptr;
    logic [M-1:0] rd_ptr;
    logic         do_write;
    logic         do_read;
    fifo_op_e     op;

    // Flags come straight from the registered count; ready ignores the read side
    assign in.ready  = (count < COUNT_FULL);
    assign out.valid = (count != '0);

    // Oldest word falls through combinationally
    assign out.data  = mem[rd_ptr];

    // Handshakes only count when the FIFO is not being reset
    assign do_write = in.valid && in.ready && !reset;
    assign do_read  = out.valid && out.ready && !reset;
    assign op       = classify_op(do_write, do_read);

    // Storage array: written on an accepted word, never cleared
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= in.data;
        end
    end

    // Pointers wrap naturally at the top of the address range
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy counter: a simultaneous write and read leave it unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case (op)
                OP_WRITE: count <= count + COUNT_ONE;
                OP_READ:  count <= count - COUNT_ONE;
                default:  count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: the driver pushes every word it expects the
// FIFO to accept, and an independent monitor pops and compares each word the
// FIFO hands out.
module tb_fifo_sync;

    logic       clk;
    logic       reset;
    logic [9:0] count;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [15:0] exp_q [$];

    FIFOInterface #(.num_bits(16)) in_if  (.clk(clk));
    FIFOInterface #(.num_bits(16)) out_if (.clk(clk));

    fifo_sync #(.Nb(16), .M(9)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_if),
        .out   (out_if),
        .count (count)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute watchdog so the run can never hang
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d compared / %0d mismatched, required completion", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison with reporting
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle inputs away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; push it to the scoreboard only when it should be accepted
    task automatic apply_stimulus(input logic [15:0] data, input logic accept);
        in_if.valid = 1'b1;
        in_if.data  = data;
        if (accept) exp_q.push_back(data);
        tick();
        in_if.valid = 1'b0;
    endtask

    // Read until empty with a bounded cycle budget, then confirm nothing is owed
    task automatic drain(input string name);
        int budget;
        budget = 0;
        out_if.ready = 1'b1;
        while (count != 0 && budget < 3000) begin
            tick();
            budget++;
        end
        out_if.ready = 1'b0;
        check_output({name, "_count"}, 32'(count), 32'd0);
        check_output({name, "_scoreboard_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a read happens at the next edge whenever valid and ready are both high
    always @(negedge clk) begin
        if (!reset && out_if.valid && out_if.ready) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL read_unexpected: got 0x%0h, required no read", out_if.data);
            end else begin
                check_output("read_data", 32'(out_if.data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int max_count;
        reset        = 1'b1;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;

        // Reset then idle
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_output("reset_count", 32'(count), 32'd0);
        check_output("reset_out_valid", 32'(out_if.valid), 32'd0);
        check_output("reset_in_ready", 32'(in_if.ready), 32'd1);

        // Single word, fall-through after one edge, then one read
        apply_stimulus(16'h1234, 1'b1);
        check_output("single_count", 32'(count), 32'd1);
        check_output("single_out_valid", 32'(out_if.valid), 32'd1);
        check_output("single_out_data", 32'(out_if.data), 32'h1234);
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
        check_output("single_after_read_count", 32'(count), 32'd0);
        check_output("single_after_read_valid", 32'(out_if.valid), 32'd0);

        // Fill to capacity, overflow attempt is dropped, drain in order
        for (int i = 0; i < 512; i++) apply_stimulus(16'(i), 1'b1);
        check_output("full_count", 32'(count), 32'd512);
        check_output("full_in_ready", 32'(in_if.ready), 32'd0);
        apply_stimulus(16'hFFFF, 1'b0);
        check_output("overflow_count", 32'(count), 32'd512);
        check_output("overflow_head", 32'(out_if.data), 32'd0);
        drain("drain_full");

        // Full with write and read in the same cycle: only the read happens
        for (int i = 0; i < 512; i++) apply_stimulus(16'(16'h4000 + i), 1'b1);
        in_if.valid  = 1'b1;
        in_if.data   = 16'hBEEF;
        out_if.ready = 1'b1;
        tick();
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        check_output("full_rw_count", 32'(count), 32'd511);
        check_output("full_rw_in_ready", 32'(in_if.ready), 32'd1);
        drain("drain_full_rw");

        // Continuous streaming across several pointer wraps
        max_count = 0;
        out_if.ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            in_if.valid = 1'b1;
            in_if.data  = 16'(16'h8000 + i);
            exp_q.push_back(in_if.data);
            tick();
            if (int'(count) > max_count) max_count = int'(count);
        end
        in_if.valid = 1'b0;
        check_output("stream_max_count", 32'(max_count), 32'd1);
        drain("drain_stream");

        // Reset in the middle of operation discards contents
        for (int i = 0; i < 100; i++) apply_stimulus(16'(16'h0C00 + i), 1'b1);
        check_output("pre_reset_count", 32'(count), 32'd100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check_output("mid_reset_count", 32'(count), 32'd0);
        check_output("mid_reset_out_valid", 32'(out_if.valid), 32'd0);
        check_output("mid_reset_in_ready", 32'(in_if.ready), 32'd1);

        // FIFO works normally after the mid-operation reset
        apply_stimulus(16'h5A5A, 1'b1);
        check_output("post_reset_head", 32'(out_if.data), 32'h5A5A);
        drain("drain_post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter Nb, default 16, data word width in bits.
REQ-002 Parameter M, default 9, address width; storage depth D = 2^M words (512 at default).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in  FIFOInterface.in  Nb  write side; in.data and in.valid are inputs, in.ready is an output.
REQ-006 out  FIFOInterface.out  Nb  read side; out.data and out.valid are outputs, out.ready is an input.
REQ-007 count  output  M+1  number of words currently stored, 0..D.
REQ-008 FIFOInterface SHALL be an interface parameterized by num_bits (default 8), with port clk and signals data[num_bits-1:0], valid, ready.
REQ-009 FIFOInterface SHALL provide modport in (data, valid input; ready output; clk input) and modport out (data, valid output; ready input; clk input).

Function
REQ-010 A write SHALL occur on a posedge where in.valid && in.ready; in.data is stored at the write pointer.
REQ-011 A read SHALL occur on a posedge where out.valid && out.ready; the read pointer advances by one.
REQ-012 in.ready SHALL be combinational: 1 when count < D, otherwise 0; it SHALL NOT depend on out.ready.
REQ-013 out.valid SHALL be combinational: 1 when count != 0, otherwise 0.
REQ-014 The FIFO SHALL be first-word-fall-through: while out.valid=1, out.data SHALL present the oldest stored word without requiring a read.
REQ-015 Write-to-read latency SHALL be one cycle: a word written into an empty FIFO at edge N SHALL appear on out.data with out.valid=1 after edge N.
REQ-016 count SHALL be a register updated per edge: +1 on write only, -1 on read only, unchanged on simultaneous write and read, unchanged when idle.
REQ-017 Pointers SHALL be M bits wide and wrap naturally from D-1 to 0.
REQ-018 When full, in.valid SHALL be ignored even if a read occurs in the same cycle; the FIFO accepts data again from the next cycle.
REQ-019 When empty, out.ready SHALL be ignored; there is no underflow and no pointer movement.
REQ-020 Data SHALL be returned in exact write order with no loss or duplication across any number of pointer wraps.
REQ-021 out.data while out.valid=0 is don't-care.

Reset
REQ-022 While reset=1 at a posedge, the read pointer, write pointer and count SHALL clear to 0, with writes and reads suppressed.
REQ-023 Immediately after reset: count=0, out.valid=0, in.ready=1.
REQ-024 Reset mid-operation SHALL discard all stored data.
REQ-025 The storage array SHALL NOT require reset.

Structure
REQ-026 FIFOInterface SHALL reside in its own shared source file, used by all FIFO-connected blocks; no package is required.
REQ-027 Storage SHALL be a D x Nb memory array inside fifo_sync; no sub-module is required.

Verification
REQ-028 Reset, then idle -> count=0, out.valid=0, in.ready=1.
REQ-029 Write 0x1234 once with out.ready=0 -> next cycle count=1, out.valid=1, out.data=0x1234; pulse out.ready -> count=0, out.valid=0.
REQ-030 Write 512 words 0..511 with out.ready=0 -> count=512, in.ready=0; a further write of 0xFFFF is ignored; draining 512 reads returns 0..511 in order.
REQ-031 Full FIFO, in.valid=1 and out.ready=1 for one cycle -> one word is read, nothing is written, count=511.
REQ-032 Continuous streaming of 2000 incrementing words with out.ready=1 -> count stays at or below 1 and output is in order across pointer wraps.
REQ-033 Reset asserted while count=100 -> count=0 and out.valid=0 on the following cycle.
